// File: rtl/adder_seq_pkg.sv
// Shared types and default constants for the adder measurement sequencer.
package adder_seq_pkg;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_CNT_W    = 32;
  localparam int unsigned DEF_WIN_W    = 16;
  localparam int unsigned DEF_WINDOW   = 1000;
  localparam int unsigned DEF_SETTLE   = 4;
  localparam int unsigned DEF_STOP_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_RUN    = 3'd4,
    ST_STOP   = 3'd5,
    ST_DONE   = 3'd6
  } seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adder_measure_sequencer_if.sv
// Command, result and adder-side signals of the measurement sequencer.
interface adder_measure_sequencer_if
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned WIN_W = DEF_WIN_W
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [WIN_W-1:0] cmd_window;
  logic             abort;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             ring_en;
  logic             cnt_clear;
  logic [WIDTH-1:0] add_sum;
  logic [CNT_W-1:0] ring_count;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_sum_ok;
  logic [CNT_W-1:0] res_count;
  logic             res_aborted;
  logic             busy;

  // Sequencer side
  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_window, abort, add_sum, ring_count, res_ready,
    output cmd_ready, add_a, add_b, ring_en, cnt_clear,
           res_valid, res_sum, res_sum_ok, res_count, res_aborted, busy
  );

  // Host plus adder side
  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_window, abort, add_sum, ring_count, res_ready,
    input  cmd_ready, add_a, add_b, ring_en, cnt_clear,
           res_valid, res_sum, res_sum_ok, res_count, res_aborted, busy
  );

endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero; times the SETTLE, RUN and STOP phases.
module seq_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/adder_measure_sequencer.sv
// Drives one add-and-measure sequence per command: load operands, settle, check the
// sum, run the ring oscillator for a window, then return sum status and ring count.
module adder_measure_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned WIN_W    = DEF_WIN_W,
  parameter int unsigned WINDOW   = DEF_WINDOW,
  parameter int unsigned SETTLE   = DEF_SETTLE,
  parameter int unsigned STOP_CYC = DEF_STOP_CYC
) (
  input logic                       wb_clk_i,
  input logic                       rst_n,
  adder_measure_sequencer_if.master bus
);

  // One shared phase timer, wide enough for the largest of the three loads
  localparam int unsigned CTR_W =
    max_u(WIN_W, max_u(int'($clog2(SETTLE)), int'($clog2(STOP_CYC))));

  seq_state_e state_q, state_d;

  logic             ctr_load;
  logic [CTR_W-1:0] ctr_load_val;
  logic             ctr_zero;
  logic             accept;
  logic [WIDTH-1:0] wrapped_sum;

  logic             cmd_ready_q,   cmd_ready_d;
  logic             busy_q,        busy_d;
  logic             ring_en_q,     ring_en_d;
  logic             cnt_clear_q,   cnt_clear_d;
  logic             res_valid_q,   res_valid_d;
  logic [WIDTH-1:0] add_a_q,       add_a_d;
  logic [WIDTH-1:0] add_b_q,       add_b_d;
  logic [WIN_W-1:0] win_q,         win_d;
  logic [WIDTH-1:0] res_sum_q,     res_sum_d;
  logic             res_sum_ok_q,  res_sum_ok_d;
  logic [CNT_W-1:0] res_count_q,   res_count_d;
  logic             res_aborted_q, res_aborted_d;

  seq_down_counter #(.W(CTR_W)) u_timer (
    .clk_i      (wb_clk_i),
    .rst_n      (rst_n),
    .load_i     (ctr_load),
    .load_val_i (ctr_load_val),
    .zero_o     (ctr_zero)
  );

  // State register
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:   state_d = ST_SETTLE;
      ST_SETTLE: if (ctr_zero) state_d = ST_CHECK;
      ST_CHECK:  state_d = ST_RUN;
      ST_RUN:    if (bus.abort || ctr_zero) state_d = ST_STOP;
      ST_STOP:   if (ctr_zero) state_d = ST_DONE;
      ST_DONE:   if (bus.res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; the timer is reloaded on entry to each timed phase
  always_comb begin
    ctr_load      = 1'b0;
    ctr_load_val  = '0;
    wrapped_sum   = add_a_q + add_b_q;
    cmd_ready_d   = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    ring_en_d     = (state_d == ST_RUN);
    cnt_clear_d   = (state_d == ST_LOAD);
    res_valid_d   = (state_d == ST_DONE);
    add_a_d       = add_a_q;
    add_b_d       = add_b_q;
    win_d         = win_q;
    res_sum_d     = res_sum_q;
    res_sum_ok_d  = res_sum_ok_q;
    res_count_d   = res_count_q;
    res_aborted_d = res_aborted_q;

    if (state_d != state_q) begin
      unique case (state_d)
        ST_SETTLE: begin
          ctr_load     = 1'b1;
          ctr_load_val = CTR_W'(SETTLE - 1);
        end
        ST_RUN: begin
          ctr_load     = 1'b1;
          ctr_load_val = CTR_W'(win_q - WIN_W'(1));
        end
        ST_STOP: begin
          ctr_load     = 1'b1;
          ctr_load_val = CTR_W'(STOP_CYC - 1);
        end
        default: ;
      endcase
    end

    if (accept) begin
      add_a_d       = bus.cmd_a;
      add_b_d       = bus.cmd_b;
      win_d         = (bus.cmd_window == '0) ? WIN_W'(WINDOW) : bus.cmd_window;
      res_aborted_d = 1'b0;
    end

    if (state_q == ST_CHECK) begin
      res_sum_d    = bus.add_sum;
      res_sum_ok_d = (bus.add_sum == wrapped_sum);
    end

    if (state_q == ST_RUN && bus.abort) begin
      res_aborted_d = 1'b1;
    end

    if (state_q == ST_STOP && state_d == ST_DONE) begin
      res_count_d = bus.ring_count;
    end
  end

  // Output and datapath registers
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      ring_en_q     <= 1'b0;
      cnt_clear_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      win_q         <= '0;
      res_sum_q     <= '0;
      res_sum_ok_q  <= 1'b0;
      res_count_q   <= '0;
      res_aborted_q <= 1'b0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      ring_en_q     <= ring_en_d;
      cnt_clear_q   <= cnt_clear_d;
      res_valid_q   <= res_valid_d;
      add_a_q       <= add_a_d;
      add_b_q       <= add_b_d;
      win_q         <= win_d;
      res_sum_q     <= res_sum_d;
      res_sum_ok_q  <= res_sum_ok_d;
      res_count_q   <= res_count_d;
      res_aborted_q <= res_aborted_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.ring_en     = ring_en_q;
  assign bus.cnt_clear   = cnt_clear_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign bus.res_sum     = res_sum_q;
  assign bus.res_sum_ok  = res_sum_ok_q;
  assign bus.res_count   = res_count_q;
  assign bus.res_aborted = res_aborted_q;

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Scoreboard bench: driver pushes expected results on accept, monitor pops on each result.
module tb_adder_measure_sequencer;
  import adder_seq_pkg::*;

  localparam int unsigned S_CYC = 4;
  localparam int unsigned P_CYC = 2;
  localparam int unsigned DEF_W = 1000;

  typedef struct {
    logic [31:0] sum;
    logic        ok;
    logic [31:0] count;
    logic        aborted;
    int          ring_len;
    int          bp;
    longint      acc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_errors = 0;
  exp_t   q[$];

  logic [31:0] ring_cnt = '0;
  int          run_len = 0;
  int          last_run = 0;
  logic        prev_rv = 1'b0;
  int          bp_left = 0;
  logic [31:0] snap_sum, snap_cnt;
  logic        snap_ok, snap_ab;

  adder_measure_sequencer_if #(.WIDTH(32), .CNT_W(32), .WIN_W(16)) bus ();

  adder_measure_sequencer #(
    .WIDTH(32), .CNT_W(32), .WIN_W(16),
    .WINDOW(DEF_W), .SETTLE(S_CYC), .STOP_CYC(P_CYC)
  ) dut (
    .wb_clk_i (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder model with a planted fault for 3+4, and its ring counter
  always_comb bus.add_sum = (bus.add_a == 32'd3 && bus.add_b == 32'd4) ? 32'd0 : bus.add_a + bus.add_b;
  always @(posedge clk) begin
    if (bus.cnt_clear) ring_cnt <= '0;
    else if (bus.ring_en) ring_cnt <= ring_cnt + 32'd1;
  end
  assign bus.ring_count = ring_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: ring_en run length, result latency, backpressure stability, result compare
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      run_len = 0;
      prev_rv = 1'b0;
      bus.res_ready = 1'b0;
    end else begin
      if (bus.ring_en) run_len++;
      else if (run_len > 0) begin
        last_run = run_len;
        run_len = 0;
      end
      if (bus.res_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 64'(bus.res_valid), 64'd0);
          bus.res_ready = 1'b1;
        end else begin
          e = q[0];
          if (!prev_rv) begin
            chk("latency", 64'(cyc - e.acc), 64'(2 + S_CYC + P_CYC + e.ring_len));
            bp_left = e.bp;
          end else begin
            chk("hold_sum", 64'(bus.res_sum), 64'(snap_sum));
            chk("hold_count", 64'(bus.res_count), 64'(snap_cnt));
            chk("hold_flags", {62'd0, bus.res_sum_ok, bus.res_aborted}, {62'd0, snap_ok, snap_ab});
          end
          snap_sum = bus.res_sum; snap_cnt = bus.res_count;
          snap_ok = bus.res_sum_ok; snap_ab = bus.res_aborted;
          if (bp_left > 0) begin
            bus.res_ready = 1'b0;
            bp_left--;
            chk("cmd_ready_in_done", 64'(bus.cmd_ready), 64'd0);
          end else begin
            bus.res_ready = 1'b1;
            chk("res_sum", 64'(bus.res_sum), 64'(e.sum));
            chk("res_sum_ok", 64'(bus.res_sum_ok), 64'(e.ok));
            chk("res_count", 64'(bus.res_count), 64'(e.count));
            chk("res_aborted", 64'(bus.res_aborted), 64'(e.aborted));
            chk("ring_en_len", 64'(last_run), 64'(e.ring_len));
            void'(q.pop_front());
          end
        end
      end else begin
        bus.res_ready = 1'b0;
      end
      prev_rv = bus.res_valid;
    end
  end

  // Issue one command; abort_at>0 pulses abort in that RUN clock, abort_settle pulses it in SETTLE
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [15:0] win,
                      input int bp, input int abort_at, input bit abort_settle);
    exp_t e;
    int   w;
    bit   got;
    w = (win == 16'd0) ? int'(DEF_W) : int'(win);
    e.sum      = (a == 32'd3 && b == 32'd4) ? 32'd0 : a + b;
    e.ok       = (e.sum == a + b);
    e.ring_len = (abort_at > 0) ? abort_at : w;
    e.count    = 32'(e.ring_len);
    e.aborted  = (abort_at > 0);
    e.bp       = bp;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_window = win;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        e.acc = cyc + 1;
        q.push_back(e);
        got = 1'b1;
      end
    end
    if (!got) chk("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (abort_settle) begin
      @(posedge clk); #1;
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
    end
    if (abort_at > 0) begin
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        got = bus.ring_en;
      end
      if (!got) chk("ring_en_timeout", 64'd0, 64'd1);
      repeat (abort_at - 1) @(posedge clk);
      #1 bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_window = '0;
    bus.abort = 1'b0; bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_ring_en", 64'(bus.ring_en), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_add_a", 64'(bus.add_a), 64'd0);
    chk("rst_cnt_clear", 64'(bus.cnt_clear), 64'd0);
    rst_n = 1'b1;

    send(32'd5, 32'd7, 16'd8, 0, 0, 1'b0);
    // Commands offered while busy must be dropped
    bus.cmd_valid = 1'b1; bus.cmd_a = 32'hDEAD; bus.cmd_b = 32'hBEEF;
    repeat (3) @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    send(32'hFFFF_FFFF, 32'd1, 16'd3, 0, 0, 1'b0);
    send(32'd3, 32'd4, 16'd5, 1, 0, 1'b0);
    send(32'd9, 32'd10, 16'd100, 0, 10, 1'b0);
    send(32'd1, 32'd2, 16'd6, 0, 0, 1'b1);
    send(32'd20, 32'd22, 16'd4, 5, 0, 1'b0);
    send(32'd7, 32'd8, 16'd0, 0, 0, 1'b0);

    // Reset in the middle of RUN
    send(32'd100, 32'd200, 16'd50, 0, 0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = bus.ring_en;
    end
    if (!done) chk("run_reached", 64'd0, 64'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ring_en", 64'(bus.ring_en), 64'd0);
    chk("arst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    chk("arst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(32'd11, 32'd12, 16'd6, 0, 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      if (i % 5 == 0) begin a = 32'd3; b = 32'd4; end
      send(a, b, 16'($urandom_range(1, 30)), int'($urandom_range(0, 3)), 0, 1'b0);
    end

    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = (q.size() == 0) && !bus.busy;
    end
    if (!done) chk("drain_timeout", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
